// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like memory port between the instruction
// fetch requester and the data requester. Only one transaction is outstanding
// at a time. Data normally wins. A run counter forces an instruction grant
// after MAX_DATA_RUN back-to-back data grants while a fetch is waiting. An
// outstanding fetch can be cancelled so that its response is dropped.
module sram_like_arbiter #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int                RUN_W   = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_DATA_RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t           state_reg;
    logic             owner_reg;   // 0 = inst, 1 = data
    logic             cancel_reg;
    logic [RUN_W-1:0] run_reg;

    logic             grant_data;
    logic             grant_inst;
    logic             sel_data;    // requester whose fields drive the memory port
    logic             drive_req;   // memory port carries a request this cycle

    // Priority decision. Data wins unless a fetch has waited through a full data run.
    always_comb begin
        grant_data = data_req && !(inst_req && (run_reg == RUN_MAX));
        grant_inst = !grant_data && inst_req;
    end

    // Choose whose fields go to memory: the live winner in IDLE, the locked owner in ADDR.
    always_comb begin
        sel_data  = 1'b0;
        drive_req = 1'b0;
        case (state_reg)
            IDLE: begin
                sel_data  = grant_data;
                drive_req = grant_data || grant_inst;
            end
            ADDR: begin
                sel_data  = owner_reg;
                drive_req = 1'b1;
            end
            default: begin
                sel_data  = owner_reg;
                drive_req = 1'b0;
            end
        endcase
    end

    // Memory port fields; zero whenever no request is presented.
    always_comb begin
        mem_req   = drive_req;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (drive_req) begin
            if (sel_data) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = 2'd2;
                mem_addr  = inst_addr;
            end
        end
    end

    // Handshake fan-back to the requesters; a cancelled fetch never reports data.
    always_comb begin
        inst_addr_ok = drive_req && mem_addr_ok && !sel_data;
        data_addr_ok = drive_req && mem_addr_ok &&  sel_data;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (state_reg == DATA && mem_data_ok) begin
            inst_data_ok = !owner_reg && !cancel_reg && !inst_cancel;
            data_data_ok =  owner_reg;
        end
        inst_rdata = mem_rdata;
        data_rdata = mem_rdata;
    end

    // Transaction FSM with owner, cancel flag and starvation run counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            cancel_reg <= 1'b0;
            run_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        owner_reg <= grant_data;
                        if (grant_data && inst_req) begin
                            if (run_reg != RUN_MAX) begin
                                run_reg <= run_reg + 1'b1;
                            end
                        end else begin
                            run_reg <= '0;
                        end
                        state_reg <= mem_addr_ok ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    // The address phase cannot be retracted, so a cancel only marks the response.
                    if (inst_cancel && !owner_reg) begin
                        cancel_reg <= 1'b1;
                    end
                    if (mem_addr_ok) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (mem_data_ok) begin
                        cancel_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end else if (inst_cancel && !owner_reg) begin
                        cancel_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter. Stimulus pushes the expected grants and
// responses into queues, and a negedge monitor pops and compares them whenever
// the DUT raises an *_addr_ok or *_data_ok.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_cancel;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        bit          is_data;
        logic [31:0] val;
    } exp_t;

    exp_t grant_q[$];
    exp_t resp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input bit d, input logic [31:0] a);
        exp_t e;
        e.is_data = d;
        e.val     = a;
        grant_q.push_back(e);
    endtask

    task automatic push_resp(input bit d, input logic [31:0] r);
        exp_t e;
        e.is_data = d;
        e.val     = r;
        resp_q.push_back(e);
    endtask

    // One zero-wait transaction: accepted this cycle, response next cycle.
    task automatic do_txn(input bit d, input logic [31:0] a, input logic [31:0] rd);
        push_grant(d, a);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        push_resp(d, rd);
        tick();
        mem_data_ok = 1'b0;
    endtask

    // Monitor: compare every accept/response the DUT presents against the queues.
    always @(negedge clk) begin
        exp_t e;
        if (inst_addr_ok || data_addr_ok) begin
            chk("addr_ok_exclusive", {31'd0, inst_addr_ok && data_addr_ok}, 32'd0);
            if (grant_q.size() == 0) begin
                chk("unexpected_addr_ok", {31'd0, data_addr_ok}, 32'hFFFF_FFFF);
            end else begin
                e = grant_q.pop_front();
                chk("grant_owner", {31'd0, data_addr_ok}, {31'd0, e.is_data});
                chk("grant_addr", mem_addr, e.val);
            end
        end
        if (inst_data_ok || data_data_ok) begin
            chk("data_ok_exclusive", {31'd0, inst_data_ok && data_data_ok}, 32'd0);
            if (resp_q.size() == 0) begin
                chk("unexpected_data_ok", {31'd0, data_data_ok}, 32'hFFFF_FFFF);
            end else begin
                e = resp_q.pop_front();
                chk("resp_owner", {31'd0, data_data_ok}, {31'd0, e.is_data});
                chk("resp_rdata", e.is_data ? data_rdata : inst_rdata, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_cancel = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'd0;
        data_wdata = 32'd0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_oks", {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 32'd0);
        tick();
        resetn = 1'b1;

        // 1: both request with zero-latency accept, data wins.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        data_req = 1'b1; data_addr = 32'h0000_0100;
        mem_addr_ok = 1'b1;
        push_grant(1'b1, 32'h0000_0100);
        @(negedge clk);
        chk("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        mem_addr_ok = 1'b0;
        @(negedge clk);
        chk("t1_data_state_no_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_0011;
        push_resp(1'b1, 32'h0000_0011);
        tick();
        mem_data_ok = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;

        // 2: both held for 6 transactions -> D,D,D,D,I,D.
        do_txn(1'b1, 32'h0000_0100, 32'hD000_0001);
        do_txn(1'b1, 32'h0000_0100, 32'hD000_0002);
        do_txn(1'b1, 32'h0000_0100, 32'hD000_0003);
        do_txn(1'b1, 32'h0000_0100, 32'hD000_0004);
        do_txn(1'b0, 32'hBFC0_0000, 32'hA000_0005);
        do_txn(1'b1, 32'h0000_0100, 32'hD000_0006);
        data_req = 1'b0;

        // 3: fetch stalled in ADDR; a data request raised meanwhile must wait.
        inst_addr = 32'hBFC0_0000; data_wdata = 32'h0000_DEAD;
        mem_addr_ok = 1'b0;
        tick();
        data_req = 1'b1; data_addr = 32'h0000_0200;
        @(negedge clk);
        chk("t3_c1_mem_addr", mem_addr, 32'hBFC0_0000);
        chk("t3_c1_inst_fields", {28'd0, mem_wr, mem_size, mem_req}, 32'd5);
        chk("t3_c1_mem_wdata", mem_wdata, 32'd0);
        tick();
        @(negedge clk);
        chk("t3_c2_mem_addr", mem_addr, 32'hBFC0_0000);
        chk("t3_c2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        push_grant(1'b0, 32'hBFC0_0000);
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("t3_c3_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h3333_3333;
        push_resp(1'b0, 32'h3333_3333);
        tick();
        mem_data_ok = 1'b0;
        do_txn(1'b1, 32'h0000_0200, 32'h4444_4444);
        data_req = 1'b0;

        // 4: cancelled fetch; its response is dropped, next data request served.
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        push_grant(1'b0, 32'hBFC0_0000);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; inst_cancel = 1'b1;
        tick();
        inst_cancel = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("t4_inst_data_ok_dropped", {31'd0, inst_data_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b0;
        data_req = 1'b1; data_addr = 32'h0000_0300;
        do_txn(1'b1, 32'h0000_0300, 32'h5555_5555);
        data_req = 1'b0;

        // 5: reset in DATA, then a stray response.
        data_req = 1'b1; data_addr = 32'h0000_0400; mem_addr_ok = 1'b1;
        push_grant(1'b1, 32'h0000_0400);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0; resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("t5_mem_req_after_reset", {31'd0, mem_req}, 32'd0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h6666_6666;
        @(negedge clk);
        chk("t5_stray_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b0;

        // 6: byte store passes wr/size/addr/wdata through unchanged.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB; mem_addr_ok = 1'b1;
        push_grant(1'b1, 32'h8000_0003);
        @(negedge clk);
        chk("t6_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("t6_mem_size", {30'd0, mem_size}, 32'd0);
        chk("t6_mem_wdata", mem_wdata, 32'h0000_00AB);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'd0;
        push_resp(1'b1, 32'd0);
        @(negedge clk);
        chk("t6_data_data_ok", {31'd0, data_data_ok}, 32'd1);
        tick();
        mem_data_ok = 1'b0;
        tick();

        chk("grant_queue_drained", grant_q.size(), 32'd0);
        chk("resp_queue_drained", resp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
